// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder sequencer. One shared generate/propagate/sum stage is
//   applied to one bit position per clock, LSB first, over WIDTH clocks.
//   The sum, the carry-out and the word-level group generate/propagate are
//   registered on the last bit. They hold until the next operation completes.
//
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : request, sampled only in IDLE
//   a, b   : WIDTH-bit operands, captured on the accepting edge
//   cin    : carry-in, captured on the accepting edge
//   busy   : high while the bit stage is being sequenced
//   done   : one-cycle pulse, results valid from this cycle on
//   sum    : a + b + cin modulo 2^WIDTH
//   cout   : carry out of bit WIDTH-1
//   grp_g  : group generate over the whole word
//   grp_p  : group propagate over the whole word
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             grp_g,
    output logic             grp_p
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] x_sr, y_sr, work;
    logic             carry, gacc, pacc;
    logic [CW-1:0]    cnt;

    // shared bit stage
    logic bg, bp, bs, carry_n, gacc_n, pacc_n;

    assign bg      = x_sr[0] & y_sr[0];
    assign bp      = x_sr[0] ^ y_sr[0];
    assign bs      = bp ^ carry;
    assign carry_n = bg | (bp & carry);
    assign gacc_n  = bg | (bp & gacc);
    assign pacc_n  = bp & pacc;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // next-state
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_next = S_RUN;
                accept     = 1'b1;
            end
            S_RUN:  if (last_bit) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // busy/done are flops fed from the next state so they carry no
    // combinational path from start and line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == S_RUN);
            done <= (state_next == S_DONE);
        end
    end

    // datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_sr  <= '0;
            y_sr  <= '0;
            work  <= '0;
            carry <= 1'b0;
            gacc  <= 1'b0;
            pacc  <= 1'b1;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            grp_g <= 1'b0;
            grp_p <= 1'b0;
        end else if (accept) begin
            x_sr  <= a;
            y_sr  <= b;
            carry <= cin;
            work  <= '0;
            gacc  <= 1'b0;
            pacc  <= 1'b1;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            x_sr  <= x_sr >> 1;
            y_sr  <= y_sr >> 1;
            // sum bits enter at the MSB; after WIDTH shifts bit 0 lands at LSB
            work  <= {bs, work[WIDTH-1:1]};
            carry <= carry_n;
            gacc  <= gacc_n;
            pacc  <= pacc_n;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                sum   <= {bs, work[WIDTH-1:1]};
                cout  <= carry_n;
                grp_g <= gacc_n;
                grp_p <= pacc_n;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an 8-bit and a 16-bit instance on one clock and
// reset. Directed vectors carry hand-computed results; the random pass uses
// plain integer addition as the reference.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        busy8, done8, cout8, g8, p8;

    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        busy16, done16, cout16, g16, p16;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .grp_g(g8), .grp_p(p8)
    );

    serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
        .grp_g(g16), .grp_p(p16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // selected instance view
    int          sel = 8;
    logic [31:0] o_sum;
    logic        o_busy, o_done, o_cout, o_g, o_p;
    always_comb begin
        if (sel == 16) begin
            o_sum = {16'h0, sum16}; o_busy = busy16; o_done = done16;
            o_cout = cout16; o_g = g16; o_p = p16;
        end else begin
            o_sum = {24'h0, sum8}; o_busy = busy8; o_done = done8;
            o_cout = cout8; o_g = g8; o_p = p8;
        end
    end

    // done pulses seen vs operations expected to complete
    int dcnt8 = 0, dcnt16 = 0, acc8 = 0, acc16 = 0;
    always @(negedge clk) begin
        if (done8)  dcnt8++;
        if (done16) dcnt16++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input logic s);
        if (w == 16) begin
            a16 = x[15:0]; b16 = y[15:0]; cin16 = c; start16 = s;
        end else begin
            a8 = x[7:0]; b8 = y[7:0]; cin8 = c; start8 = s;
        end
    endtask

    // One complete operation with latency, busy-length and result checks.
    task automatic run_op(input int w, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input string tag,
                          input logic [31:0] e_sum, input logic e_cout,
                          input logic e_g, input logic e_p);
        int n, nb;
        sel = w;
        @(negedge clk);
        set_in(w, x, y, c, 1'b1);
        @(negedge clk);                      // accepting edge E0 has passed
        set_in(w, ~x, ~y, ~c, 1'b0);         // later operand changes must not matter
        n = 0; nb = 0;
        while (!o_done && n < 4 * w + 10) begin
            if (o_busy) nb++;
            @(negedge clk);
            n++;
        end
        chk({tag, ":latency"}, 32'(n), 32'(w));
        chk({tag, ":busy_cycles"}, 32'(nb), 32'(w));
        chk({tag, ":busy_with_done"}, {31'h0, o_busy}, 32'h0);
        chk({tag, ":sum"}, o_sum, e_sum);
        chk({tag, ":cout"}, {31'h0, o_cout}, {31'h0, e_cout});
        chk({tag, ":grp_g"}, {31'h0, o_g}, {31'h0, e_g});
        chk({tag, ":grp_p"}, {31'h0, o_p}, {31'h0, e_p});
        chk({tag, ":gp_invariant"}, {31'h0, o_cout}, {31'h0, o_g | (o_p & c)});
        @(negedge clk);
        chk({tag, ":done_one_cycle"}, {31'h0, o_done}, 32'h0);
        chk({tag, ":hold_sum"}, o_sum, e_sum);
        if (w == 16) acc16++; else acc8++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d1, d2, ndone;
        logic [31:0] s1, s2;
        logic        c1;

        // reset state
        #12;
        sel = 8;
        chk("rst:sum", o_sum, 32'h0);
        chk("rst:cout", {31'h0, o_cout}, 32'h0);
        chk("rst:grp_g", {31'h0, o_g}, 32'h0);
        chk("rst:grp_p", {31'h0, o_p}, 32'h0);
        chk("rst:busy", {31'h0, o_busy}, 32'h0);
        chk("rst:done", {31'h0, o_done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // directed, hand-computed
        run_op(8, 32'h00, 32'h00, 1'b0, "zero",      32'h00, 1'b0, 1'b0, 1'b0);
        run_op(8, 32'hFF, 32'h01, 1'b0, "ff_01",     32'h00, 1'b1, 1'b1, 1'b0);
        run_op(8, 32'hAA, 32'h55, 1'b1, "aa_55_c1",  32'h00, 1'b1, 1'b0, 1'b1);
        run_op(8, 32'hAA, 32'h55, 1'b0, "aa_55_c0",  32'hFF, 1'b0, 1'b0, 1'b1);
        run_op(16, 32'hFFFF, 32'h0001, 1'b0, "w16_ffff_1", 32'h0000, 1'b1, 1'b1, 1'b0);

        // start held high: mid-run start ignored, next accept at E0+10
        sel = 8;
        @(negedge clk);
        set_in(8, 32'h3C, 32'h5A, 1'b0, 1'b1);
        @(negedge clk);                      // after E0
        n = 0; d1 = -1; d2 = -1; ndone = 0; s1 = '0; s2 = '0; c1 = 1'b1;
        while (n < 22) begin
            @(negedge clk);
            n++;
            if (n == 2) begin a8 = 8'h01; b8 = 8'h01; end
            if (n == 5)  chk("held:busy_mid", {31'h0, o_busy}, 32'h1);
            if (n == 9)  chk("held:idle_gap", {31'h0, o_busy | o_done}, 32'h0);
            if (n == 10) begin
                chk("held:reaccept", {31'h0, o_busy}, 32'h1);
                start8 = 1'b0;
            end
            if (o_done) begin
                ndone++;
                if (d1 < 0) begin d1 = n; s1 = o_sum; c1 = o_cout; end
                else if (d2 < 0) begin d2 = n; s2 = o_sum; end
            end
        end
        chk("held:done1_at", 32'(d1), 32'd8);
        chk("held:sum1", s1, 32'h96);
        chk("held:cout1", {31'h0, c1}, 32'h0);
        chk("held:done2_at", 32'(d2), 32'd18);
        chk("held:sum2", s2, 32'h02);
        chk("held:done_count", 32'(ndone), 32'd2);
        acc8 += 2;

        // reset mid-run while processing bit 3 of 0xFF+0xFF
        @(negedge clk);
        set_in(8, 32'hFF, 32'hFF, 1'b0, 1'b1);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort:sum", o_sum, 32'h0);
        chk("abort:cout", {31'h0, o_cout}, 32'h0);
        chk("abort:busy", {31'h0, o_busy}, 32'h0);
        chk("abort:done", {31'h0, o_done}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_done) ndone++;
        end
        chk("abort:no_done", 32'(ndone), 32'd0);
        run_op(8, 32'h10, 32'h20, 1'b0, "post_abort", 32'h30, 1'b0, 1'b0, 1'b0);

        // random, reference is integer addition
        for (int w = 8; w <= 16; w += 8) begin
            for (int i = 0; i < 2000; i++) begin
                logic [31:0] mask, x, y, xy;
                logic [32:0] tot;
                logic        c;
                mask = (w == 16) ? 32'hFFFF : 32'hFF;
                x = $urandom & mask;
                y = $urandom & mask;
                c = 1'($urandom_range(0, 1));
                tot = {1'b0, x} + {1'b0, y} + {32'h0, c};
                xy  = x + y;                 // carry-out with cin=0 is group generate
                run_op(w, x, y, c, (w == 16) ? "rnd16" : "rnd8",
                       tot[31:0] & mask, tot[w], xy[w], ((x ^ y) == mask));
            end
        end

        chk("done_count8", 32'(dcnt8), 32'(acc8));
        chk("done_count16", 32'(dcnt16), 32'(acc16));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that time-shares a single bit stage across all bits of an operand pair. It accepts WIDTH-bit operands and a carry-in under a start/busy/done handshake, and applies one bit position per clock (LSB first) through the generate/propagate/sum function. It produces the WIDTH-bit sum, the carry-out, and the ripple-combined group generate/propagate for the whole word. It sits between a requester and the adder datapath; it is the sequencer for the bit-stage resource.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range 2 to 32.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand x, captured on the accepting edge.
- b  input  WIDTH  operand y, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- grp_g  output  1  group generate over all WIDTH bits.
- grp_p  output  1  group propagate over all WIDTH bits.

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE with start=1 at an edge → RUN:
  - a and b load into shift registers; cin loads into the carry register.
  - bit counter = 0; internal group accumulators gacc = 0, pacc = 1.
  - sum working register cleared.
- RUN, each edge, for bit i (the LSB of each operand shift register), with c the carry register:
  - g = x&y, p = x^y, s = x^y^c.
  - carry ← g | (p&c).
  - gacc ← g | (p&gacc); pacc ← p&pacc.
  - s shifts into the MSB of the sum working register (shift right); both operand registers shift right.
  - counter increments.
- RUN on the edge processing bit WIDTH-1 → DONE:
  - the final values are copied to the output registers: sum ← the working register including this edge's s; cout ← the updated carry; grp_g ← updated gacc; grp_p ← updated pacc.
- DONE → IDLE on the next edge, unconditionally.
- start is ignored in RUN and DONE. It is not queued and there is no error flag.
- Result outputs hold their values until the next DONE overwrites them, across IDLE and through subsequent RUN periods.
- Invariant: cout == grp_g | (grp_p & cin of that operation).
- Arithmetic is unsigned. There is no overflow flag beyond cout.

## Timing
- Reset (async, takes effect immediately):
  - state = IDLE; busy = 0, done = 0.
  - sum = 0, cout = 0, grp_g = 0, grp_p = 0.
  - all internal registers cleared; pacc = 1.
- Reset asserted mid-RUN aborts the operation: no done pulse, outputs forced to reset values. The first edge after rst deasserts may accept start.
- Latency:
  - start accepted at edge E0.
  - busy = 1 after E0 through edge E0+WIDTH.
  - done = 1 for the single cycle between E0+WIDTH and E0+WIDTH+1; results are valid from E0+WIDTH.
- Throughput:
  - state is IDLE after E0+WIDTH+1.
  - the earliest next accept is at edge E0+WIDTH+2, i.e. one operation per WIDTH+2 cycles with start held high.
- busy and done are registered outputs, never asserted together, and have no combinational path from start.
- Operands are captured at E0; changes on a, b and cin after E0 do not affect the operation.

## Test plan
- Reset, then 0x00+0x00, cin=0 → sum=0x00, cout=0, grp_g=0, grp_p=0. done rises exactly 8 cycles after the accepting edge; busy is high for 8 cycles.
- 0xFF+0x01, cin=0 → sum=0x00, cout=1, grp_g=1, grp_p=0.
- 0xAA+0x55, cin=1 → sum=0x00, cout=1, grp_g=0, grp_p=1. Repeat with cin=0 → sum=0xFF, cout=0, grp_p=1.
- 0x3C+0x5A, cin=0, with start held high and operands changed to 0x01/0x01 at cycles 2-5 of RUN:
  - first result sum=0x96, cout=0.
  - the mid-run start is ignored.
  - the second operation is accepted at E0+10 and gives sum=0x02.
- Assert rst during RUN at bit 3 of 0xFF+0xFF → outputs return to 0 immediately and no done pulse occurs. Then 0x10+0x20 → sum=0x30, cout=0.
- 2000 random operations at WIDTH=8 and WIDTH=16, checked against a+b+cin. Check cout == grp_g|(grp_p&cin) and exactly one done per accepted start.
